// File: rtl/alu_ctrl.sv
// Multi-cycle controller: fetch, execute on an external ALU, write back.
// Optional retire counter is enabled by defining ALU_CTRL_RETIRE_CNT_EN.
module alu_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [6:0]  alu_instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_reg8,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    output logic        alu_f1,
    output logic        alu_f2,
    input  logic [31:0] alu_c,
    input  logic        alu_f3,
    input  logic        alu_addrch,
    input  logic [31:0] alu_naddr,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic             f1_q, f1_d, f2_q, f2_d;
    logic [15:0][31:0] regs_q, regs_d;
    logic [31:0]      c_q, naddr_q;
    logic             f3_q, addrch_q;

    logic [6:0]  opc;
    logic [3:0]  rd, ra, rb;
    logic [15:0] imm;
    logic        op_wr, op_cmp, op_ill, op_halt;

    assign opc     = ir_q[31:25];
    assign rd      = ir_q[24:21];
    assign ra      = ir_q[20:17];
    assign rb      = ir_q[16:13];
    assign imm     = ir_q[15:0];
    assign op_wr   = (opc < 7'd8);
    assign op_cmp  = (opc >= 7'd8) && (opc <= 7'd13);
    assign op_ill  = (opc >= 7'd16) && (opc <= 7'd126);
    assign op_halt = (opc == 7'd127);

    assign imem_addr = pc_q;
    assign alu_reg8  = regs_q[8];
    assign alu_f1    = f1_q;
    assign alu_f2    = f2_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            f1_q     <= 1'b0;
            f2_q     <= 1'b0;
            regs_q   <= '0;
            c_q      <= '0;
            naddr_q  <= '0;
            f3_q     <= 1'b0;
            addrch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            regs_q  <= regs_d;
            if (state_q == S_EXEC) begin
                c_q      <= alu_c;
                naddr_q  <= alu_naddr;
                f3_q     <= alu_f3;
                addrch_q <= alu_addrch;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        f1_d        = f1_q;
        f2_d        = f2_q;
        regs_d      = regs_q;
        imem_req    = 1'b0;
        alu_instr   = 7'd127;
        alu_a       = '0;
        alu_b       = '0;
        alu_value   = '0;
        alu_highlow = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_instr   = opc;
                alu_a       = regs_q[ra];
                alu_b       = regs_q[rb];
                alu_value   = imm;
                alu_highlow = (opc == 7'd5);
                state_d     = S_WB;
            end
            S_WB: begin
                state_d = S_FETCH;
                if (op_wr && (rd != 4'd0)) regs_d[rd] = c_q;
                if (op_cmp) begin
                    f2_d = f1_q;
                    f1_d = f3_q;
                end
                // Halt keeps pc on the halting instruction; illegal ops ignore any branch request
                if (op_halt) begin
                    state_d = S_HALT;
                end else if (op_ill) begin
                    illegal = 1'b1;
                    pc_d    = pc_q + 32'd1;
                end else begin
                    pc_d = addrch_q ? naddr_q : pc_q + 32'd1;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
        if (!reset_n) begin
            imem_req = 1'b0;
            illegal  = 1'b0;
            halted   = 1'b0;
        end
    end

`ifdef ALU_CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q;
    always_ff @(posedge clock) begin
        if (!reset_n)               retired_q <= '0;
        else if (state_q == S_WB)   retired_q <= retired_q + 32'd1;
    end
    assign retired = retired_q;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: vector table, directed sequences, and random
// programs checked against an instruction-level reference model.
module tb_alu_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic [6:0]  alu_instr;
    logic [31:0] alu_a, alu_b, alu_reg8, alu_c, alu_naddr;
    logic [15:0] alu_value;
    logic        alu_highlow, alu_f1, alu_f2, alu_f3, alu_addrch;
    logic        halted, illegal;
    logic [31:0] retired;

`ifdef ALU_CTRL_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    alu_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_reg8(alu_reg8),
        .alu_value(alu_value), .alu_highlow(alu_highlow), .alu_f1(alu_f1), .alu_f2(alu_f2),
        .alu_c(alu_c), .alu_f3(alu_f3), .alu_addrch(alu_addrch), .alu_naddr(alu_naddr),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] c;
        logic        f3;
        logic        ach;
        logic [31:0] na;
    } alu_res_t;

    // Behavioural ALU attached to the controller
    function automatic alu_res_t alu_fn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [15:0] v, input logic f1, input logic f2,
                                        input logic [31:0] r8);
        alu_res_t r;
        r = '0;
        case (op)
            7'd0:  r.c = a + b;
            7'd1:  r.c = a - b;
            7'd2:  r.c = a & b;
            7'd3:  r.c = a | b;
            7'd4:  r.c = a ^ b;
            7'd5:  r.c = {16'h0, v};
            7'd6:  r.c = {v, a[15:0]};
            7'd7:  r.c = a + {{16{v[15]}}, v};
            7'd8:  r.f3 = (a == b);
            7'd9:  r.f3 = (a < b);
            7'd10: r.f3 = ($signed(a) < $signed(b));
            7'd11: r.f3 = (a != b);
            7'd12: r.f3 = f1 & f2;
            7'd13: r.f3 = f1 | f2;
            7'd14: begin r.ach = 1'b1; r.na = a; end
            7'd15: begin r.ach = f1;   r.na = r8; end
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_res_t r;
        r = alu_fn(alu_instr, alu_a, alu_b, alu_value, alu_f1, alu_f2, alu_reg8);
        alu_c      = r.c;
        alu_f3     = r.f3;
        alu_addrch = r.ach;
        alu_naddr  = r.na;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Instruction-level reference model
    logic [31:0] m_reg [16];
    logic [31:0] m_pc, m_ret, last_a;
    logic        m_f1, m_f2, m_halt;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_pc = '0; m_ret = '0; m_f1 = 1'b0; m_f2 = 1'b0; m_halt = 1'b0;
    endtask

    task automatic iss(input logic [31:0] w);
        logic [6:0] op;
        logic [3:0] rd, ra, rb;
        alu_res_t   r;
        op = w[31:25]; rd = w[24:21]; ra = w[20:17]; rb = w[16:13];
        r = alu_fn(op, m_reg[ra], m_reg[rb], w[15:0], m_f1, m_f2, m_reg[8]);
        m_ret = m_ret + 1;
        if (op == 7'd127) begin
            m_halt = 1'b1;
        end else if (op >= 7'd16) begin
            m_pc = m_pc + 1;
        end else begin
            if (op < 7'd8 && rd != 4'd0) m_reg[rd] = r.c;
            if (op >= 7'd8 && op <= 7'd13) begin m_f2 = m_f1; m_f1 = r.f3; end
            m_pc = r.ach ? r.na : m_pc + 1;
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [6:0] op, input logic [3:0] rd, input logic [3:0] ra,
                                         input logic [3:0] rb);
        return {op, rd, ra, rb, 13'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [6:0] op, input logic [3:0] rd, input logic [3:0] ra,
                                         input logic [15:0] imm);
        return {op, rd, ra, 1'b0, imm};
    endfunction

    // Holds reset for n cycles with a spurious ack; returns at a negedge with reset released
    task automatic do_reset(input int n);
        reset_n  = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock); #1;
            chk("rst_req", imem_req, 1'b0);
        end
        @(negedge clock);
        reset_n  = 1'b1;
        imem_ack = 1'b0;
        model_reset();
    endtask

    // Runs one instruction from a FETCH cycle; returns at the negedge after WB
    task automatic do_instr(input logic [31:0] w, input int dly);
        logic [3:0] ra, rb;
        ra = w[20:17]; rb = w[16:13];
        for (int i = 0; i <= dly; i++) begin
            imem_ack  = (i == dly);
            imem_data = (i == dly) ? w : $urandom;
            #1;
            chk("fetch_req", imem_req, 1'b1);
            chk("fetch_addr", imem_addr, m_pc);
            if (i == 0) begin
                chk("halted0", halted, 1'b0);
                chk("retired", retired, RET_EN ? m_ret : 32'd0);
                chk("reg8", alu_reg8, m_reg[8]);
                chk("idle_instr", alu_instr, 7'd127);
                chk("idle_opnd", {alu_a | alu_b | {16'h0, alu_value}}, 32'd0);
                chk("idle_hl", alu_highlow, 1'b0);
            end
            @(negedge clock);
        end
        imem_ack  = 1'b0;
        imem_data = $urandom;
        #1;
        chk("exec_instr", alu_instr, w[31:25]);
        chk("exec_a", alu_a, m_reg[ra]);
        chk("exec_b", alu_b, m_reg[rb]);
        chk("exec_val", alu_value, w[15:0]);
        chk("exec_hl", alu_highlow, w[31:25] == 7'd5);
        chk("exec_f", {alu_f2, alu_f1}, {m_f2, m_f1});
        chk("exec_req", imem_req, 1'b0);
        last_a = alu_a;
        @(negedge clock); #1;
        chk("wb_ill", illegal, (w[31:25] >= 7'd16) && (w[31:25] <= 7'd126));
        chk("wb_instr", alu_instr, 7'd127);
        iss(w);
        @(negedge clock);
    endtask

    task automatic check_halt(input int n);
        imem_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("halt_flag", halted, 1'b1);
            chk("halt_req", imem_req, 1'b0);
            chk("halt_pc", imem_addr, m_pc);
            @(negedge clock);
        end
        imem_ack = 1'b0;
    endtask

    typedef struct {
        logic [31:0] w;
        logic [6:0]  eop;
        logic [15:0] eval;
        logic        ehl;
        logic        eill;
        logic [31:0] epc;
        logic        ehalt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w, rw;
        logic [6:0]  op;
        vecs[0] = '{32'h0A00_1234, 7'd5,   16'h1234, 1'b1, 1'b0, 32'd1, 1'b0};
        vecs[1] = '{32'hA000_0000, 7'd80,  16'h0000, 1'b0, 1'b1, 32'd1, 1'b0};
        vecs[2] = '{32'hFE00_0000, 7'd127, 16'h0000, 1'b0, 1'b0, 32'd0, 1'b1};
        vecs[3] = '{32'h1E00_FFFF, 7'd15,  16'hFFFF, 1'b0, 1'b0, 32'd1, 1'b0};
        vecs[4] = '{32'h1C00_0000, 7'd14,  16'h0000, 1'b0, 1'b0, 32'd0, 1'b0};
        vecs[5] = '{32'h2000_00AA, 7'd16,  16'h00AA, 1'b0, 1'b1, 32'd1, 1'b0};
        vecs[6] = '{32'hFC00_5555, 7'd126, 16'h5555, 1'b0, 1'b1, 32'd1, 1'b0};
        vecs[7] = '{32'h1A00_0000, 7'd13,  16'h0000, 1'b0, 1'b0, 32'd1, 1'b0};
        vecs[8] = '{32'h0E00_8000, 7'd7,   16'h8000, 1'b0, 1'b0, 32'd1, 1'b0};

        reset_n = 1'b0; imem_ack = 1'b0; imem_data = '0;
        do_reset(2);
        #1;
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_req1", imem_req, 1'b1);
        chk("rst_halted", halted, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_flags", {alu_f2, alu_f1}, 2'b00);
        chk("rst_instr", alu_instr, 7'd127);

        foreach (vecs[i]) begin
            do_reset(1);
            imem_ack = 1'b1; imem_data = vecs[i].w;
            @(negedge clock);
            imem_ack = 1'b0; #1;
            chk("vec_op", alu_instr, vecs[i].eop);
            chk("vec_val", alu_value, vecs[i].eval);
            chk("vec_hl", alu_highlow, vecs[i].ehl);
            @(negedge clock); #1;
            chk("vec_ill", illegal, vecs[i].eill);
            @(negedge clock); #1;
            chk("vec_pc", imem_addr, vecs[i].epc);
            chk("vec_halt", halted, vecs[i].ehalt);
            chk("vec_req", imem_req, !vecs[i].ehalt);
            chk("vec_ill_drop", illegal, 1'b0);
        end

        // Load high/low halves into r1
        do_reset(1);
        do_instr(mk_i(7'd5, 4'd1, 4'd0, 16'h1234), 0);
        do_instr(mk_i(7'd6, 4'd1, 4'd1, 16'hABCD), 0);
        #1;
        chk("load_pc", imem_addr, 32'd2);
        chk("load_ret", retired, RET_EN ? 32'd2 : 32'd0);
        do_instr(mk_r(7'd0, 4'd0, 4'd1, 4'd0), 1);
        chk("load_r1", last_a, 32'hABCD_1234);

        // 32-bit add wrap with F1 preset
        do_reset(1);
        do_instr(mk_r(7'd8, 4'd0, 4'd0, 4'd0), 0);
        do_instr(mk_i(7'd5, 4'd2, 4'd0, 16'hFFFF), 0);
        do_instr(mk_i(7'd6, 4'd2, 4'd2, 16'hFFFF), 0);
        do_instr(mk_i(7'd5, 4'd3, 4'd0, 16'h0001), 0);
        do_instr(mk_r(7'd0, 4'd4, 4'd2, 4'd3), 0);
        #1;
        chk("add_f1", alu_f1, 1'b1);
        do_instr(mk_r(7'd1, 4'd0, 4'd4, 4'd2), 0);
        chk("add_r4", last_a, 32'd0);

        // Branch taken / not taken on F1, r8 target
        do_reset(1);
        do_instr(mk_r(7'd8, 4'd0, 4'd0, 4'd0), 0);
        do_instr(mk_i(7'd5, 4'd8, 4'd0, 16'h0040), 0);
        do_instr(mk_r(7'd15, 4'd0, 4'd0, 4'd0), 0);
        #1;
        chk("br_taken", imem_addr, 32'h40);
        do_instr(mk_r(7'd9, 4'd0, 4'd0, 4'd0), 0);
        do_instr(mk_r(7'd15, 4'd0, 4'd0, 4'd0), 0);
        #1;
        chk("br_not_taken", imem_addr, 32'h42);

        // pc wrap through jump to 0xFFFFFFFF
        do_instr(mk_i(7'd5, 4'd9, 4'd0, 16'hFFFF), 0);
        do_instr(mk_i(7'd6, 4'd9, 4'd9, 16'hFFFF), 0);
        do_instr(mk_r(7'd14, 4'd0, 4'd9, 4'd0), 0);
        #1;
        chk("pc_max", imem_addr, 32'hFFFF_FFFF);
        do_instr(mk_r(7'd0, 4'd0, 4'd0, 4'd0), 0);
        #1;
        chk("pc_wrap", imem_addr, 32'd0);

        // Fetch stall of 5 cycles
        do_instr(mk_r(7'd2, 4'd6, 4'd9, 4'd9), 5);

        // Reset during writeback discards the write
        do_reset(1);
        do_instr(mk_i(7'd5, 4'd2, 4'd0, 16'h0003), 0);
        do_instr(mk_i(7'd5, 4'd3, 4'd0, 16'h0004), 0);
        imem_ack = 1'b1; imem_data = mk_r(7'd0, 4'd5, 4'd2, 4'd3);
        @(negedge clock);
        imem_ack = 1'b0; #1;
        chk("rstwb_exec_a", alu_a, 32'd3);
        @(negedge clock);
        reset_n = 1'b0; #1;
        chk("rstwb_req", imem_req, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        #1;
        chk("rstwb_addr", imem_addr, 32'd0);
        chk("rstwb_req1", imem_req, 1'b1);
        do_instr(mk_r(7'd0, 4'd0, 4'd5, 4'd0), 0);
        chk("rstwb_r5", last_a, 32'd0);

        // Illegal opcode then halt
        do_instr(mk_r(7'h50, 4'd1, 4'd0, 4'd0), 0);
        #1;
        chk("ill_pc", imem_addr, 32'd2);
        chk("ill_pulse_end", illegal, 1'b0);
        do_instr(mk_r(7'd127, 4'd0, 4'd0, 4'd0), 0);
        check_halt(100);

        // Random programs against the reference model
        do_reset(1);
        for (int i = 0; i < 150; i++) begin
            rw = $urandom;
            op = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(16, 126));
            w  = {op, rw[24:0]};
            do_instr(w, $urandom_range(0, 3));
        end
        do_instr(mk_r(7'd127, 4'd0, 4'd0, 4'd0), 1);
        check_halt(5);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
